// File: rtl/fc_pkg.sv
`default_nettype none
// ============================================================================
// Package : fc
// Shared FC link constants: ordered-set words, primitive sequence and word
// class encodings. Revision: 1.0
// ============================================================================
package fc;

  localparam logic [7:0]  K28_5 = 8'hBC;

  localparam logic [31:0] IDLE = 32'hBC95_B5B5;
  localparam logic [31:0] LR   = 32'hBC49_BF49;
  localparam logic [31:0] LRR  = 32'hBC35_BF49;
  localparam logic [31:0] OLS  = 32'hBC35_8A55;
  localparam logic [31:0] NOS  = 32'hBC55_BF45;

  typedef enum logic [2:0] {
    SEQ_NONE = 3'd0,
    SEQ_IDLE = 3'd1,
    SEQ_LR   = 3'd2,
    SEQ_LRR  = 3'd3,
    SEQ_OLS  = 3'd4,
    SEQ_NOS  = 3'd5
  } prim_seq_t;

  typedef enum logic [1:0] {
    CLS_DATA  = 2'd0,
    CLS_OTHER = 2'd1,
    CLS_SEQ   = 2'd2
  } os_class_t;

endpackage
`default_nettype wire

// File: rtl/fc_os_classify.sv
`default_nettype none
// ============================================================================
// Module : fc_os_classify
// Combinational word-to-class decoder for received 32-bit words. Revision: 1.0
// ============================================================================
module fc_os_classify
  import fc::*;
(
  input  logic [31:0] data_i,
  input  logic [3:0]  datak_i,
  output os_class_t   cls_o,
  output prim_seq_t   seq_o,
  output logic        k28_5_o
);

  always_comb begin
    cls_o   = CLS_OTHER;
    seq_o   = SEQ_NONE;
    k28_5_o = (data_i[31:24] == K28_5);
    if (datak_i == 4'b0000) begin
      cls_o = CLS_DATA;
    end else if ((datak_i == 4'b1000) && k28_5_o) begin
      cls_o = CLS_SEQ;
      case (data_i)
        IDLE:    seq_o = SEQ_IDLE;
        LR:      seq_o = SEQ_LR;
        LRR:     seq_o = SEQ_LRR;
        OLS:     seq_o = SEQ_OLS;
        NOS:     seq_o = SEQ_NOS;
        default: cls_o = CLS_OTHER;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/fc_primseq_rx.sv
`default_nettype none
// ============================================================================
// Module : fc_primseq_rx
// RX primitive sequence recogniser; optional counters under FC_PRIMSEQ_RX_STATS_EN.
// Revision: 1.0
// ============================================================================
module fc_primseq_rx
  import fc::*;
#(
  parameter int unsigned RECOG_COUNT = 3
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] data_i,
  input  logic [3:0]  datak_i,
  input  logic        valid_i,
  input  logic        sync_i,
`ifdef FC_PRIMSEQ_RX_STATS_EN
  output logic [15:0] stat_seq_changes_o,
  output logic [15:0] stat_other_os_o,
`endif
  output prim_seq_t   rx_seq_o,
  output logic        rx_seq_change_o,
  output logic        loss_of_sync_o
);

  localparam int              CW      = $clog2(RECOG_COUNT + 1);
  localparam logic [CW-1:0]   CNT_MAX = CW'(RECOG_COUNT);

  os_class_t      cls_w;
  prim_seq_t      seq_w;
  logic           s1_valid_q;
  os_class_t      s1_cls_q;
  prim_seq_t      s1_seq_q;
  prim_seq_t      cand_q, cand_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           recog_d, chg_d;
  prim_seq_t      rx_seq_q;
  logic           chg_q, los_q;

`ifdef FC_PRIMSEQ_RX_STATS_EN
  logic           k28_5_w;
  logic           s1_k_q;
`endif

  fc_os_classify u_classify (
    .data_i  (data_i),
    .datak_i (datak_i),
    .cls_o   (cls_w),
    .seq_o   (seq_w),
`ifdef FC_PRIMSEQ_RX_STATS_EN
    .k28_5_o (k28_5_w)
`else
    .k28_5_o ()
`endif
  );

  // Run tracking: the candidate holds the current run of identical known sets.
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    if (s1_valid_q) begin
      if (s1_cls_q == CLS_SEQ) begin
        if (s1_seq_q == cand_q) begin
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        end else begin
          cand_d = s1_seq_q;
          cnt_d  = CW'(1);
        end
      end else begin
        cand_d = SEQ_NONE;
        cnt_d  = '0;
      end
    end
    recog_d = s1_valid_q && (cnt_d == CNT_MAX) && (cand_d != rx_seq_q);
    chg_d   = sync_i ? recog_d : (rx_seq_q != SEQ_NONE);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s1_valid_q <= 1'b0;
      s1_cls_q   <= CLS_DATA;
      s1_seq_q   <= SEQ_NONE;
      cand_q     <= SEQ_NONE;
      cnt_q      <= '0;
      rx_seq_q   <= SEQ_NONE;
      chg_q      <= 1'b0;
      los_q      <= 1'b1;
    end else begin
      los_q <= ~sync_i;
      chg_q <= chg_d;
      if (!sync_i) begin
        s1_valid_q <= 1'b0;
        cand_q     <= SEQ_NONE;
        cnt_q      <= '0;
        rx_seq_q   <= SEQ_NONE;
      end else begin
        s1_valid_q <= valid_i;
        if (valid_i) begin
          s1_cls_q <= cls_w;
          s1_seq_q <= seq_w;
        end
        cand_q <= cand_d;
        cnt_q  <= cnt_d;
        if (recog_d) rx_seq_q <= cand_d;
      end
    end
  end

`ifdef FC_PRIMSEQ_RX_STATS_EN
  logic [15:0] stat_chg_q, stat_oth_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s1_k_q     <= 1'b0;
      stat_chg_q <= '0;
      stat_oth_q <= '0;
    end else begin
      if (sync_i && valid_i) s1_k_q <= k28_5_w;
      if (chg_d && (stat_chg_q != 16'hFFFF)) stat_chg_q <= stat_chg_q + 16'd1;
      if (sync_i && s1_valid_q && (s1_cls_q == CLS_OTHER) && s1_k_q &&
          (stat_oth_q != 16'hFFFF))
        stat_oth_q <= stat_oth_q + 16'd1;
    end
  end

  assign stat_seq_changes_o = stat_chg_q;
  assign stat_other_os_o    = stat_oth_q;
`endif

  assign rx_seq_o        = rx_seq_q;
  assign rx_seq_change_o = chg_q;
  assign loss_of_sync_o  = los_q;

endmodule
`default_nettype wire

// File: tb/tb_fc_primseq_rx.sv
`default_nettype none
// ============================================================================
// Module : tb_fc_primseq_rx
// Directed + random stimulus against a history-based model. Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_fc_primseq_rx;
  import fc::*;

  localparam int RC = 3;
  localparam logic [31:0] W_IDLE = 32'hBC95B5B5;
  localparam logic [31:0] W_LR   = 32'hBC49BF49;
  localparam logic [31:0] W_LRR  = 32'hBC35BF49;
  localparam logic [31:0] W_OLS  = 32'hBC358A55;
  localparam logic [31:0] W_NOS  = 32'hBC55BF45;
  localparam logic [31:0] W_RRDY = 32'hBC954A4A;

  logic        clk = 1'b0;
  logic        reset, valid, sync;
  logic [31:0] data;
  logic [3:0]  datak;
  prim_seq_t   rx_seq;
  logic        rx_seq_change, loss_of_sync;
`ifdef FC_PRIMSEQ_RX_STATS_EN
  logic [15:0] stat_seq_changes, stat_other_os;
  int          m_sc, m_oo;
  bit          pend_bc;
`endif

  fc_primseq_rx #(.RECOG_COUNT(RC)) dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .data_i          (data),
    .datak_i         (datak),
    .valid_i         (valid),
    .sync_i          (sync),
`ifdef FC_PRIMSEQ_RX_STATS_EN
    .stat_seq_changes_o (stat_seq_changes),
    .stat_other_os_o    (stat_other_os),
`endif
    .rx_seq_o        (rx_seq),
    .rx_seq_change_o (rx_seq_change),
    .loss_of_sync_o  (loss_of_sync)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int pulses  = 0;

  // Model: recognised when the last RC qualifying words are one known sequence.
  int hist[$];
  int pend;
  bit pend_v = 1'b0;
  int m_rx = 0;
  bit m_chg = 1'b0;
  bit m_los = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // -1 = data, -2 = other, otherwise the sequence code.
  function automatic int classify(input logic [31:0] w, input logic [3:0] k);
    if (k == 4'b0000) return -1;
    if (k != 4'b1000 || w[31:24] != 8'hBC) return -2;
    case (w)
      W_IDLE:  return int'(SEQ_IDLE);
      W_LR:    return int'(SEQ_LR);
      W_LRR:   return int'(SEQ_LRR);
      W_OLS:   return int'(SEQ_OLS);
      W_NOS:   return int'(SEQ_NOS);
      default: return -2;
    endcase
  endfunction

  task automatic model_step(input bit r, input bit s, input bit v,
                            input logic [31:0] w, input logic [3:0] k);
    bit same;
    m_chg = 1'b0;
    if (r) begin
      hist.delete(); pend_v = 1'b0; m_rx = int'(SEQ_NONE); m_los = 1'b1;
`ifdef FC_PRIMSEQ_RX_STATS_EN
      m_sc = 0; m_oo = 0;
`endif
    end else if (!s) begin
      hist.delete(); pend_v = 1'b0; m_los = 1'b1;
      m_chg = (m_rx != int'(SEQ_NONE));
      m_rx  = int'(SEQ_NONE);
    end else begin
      m_los = 1'b0;
      if (pend_v) begin
        if (pend < 0) hist.delete();
        else begin
          hist.push_back(pend);
          if (hist.size() > RC) void'(hist.pop_front());
        end
`ifdef FC_PRIMSEQ_RX_STATS_EN
        if (pend == -2 && pend_bc && m_oo < 65535) m_oo++;
`endif
        if (pend >= 0 && hist.size() == RC) begin
          same = 1'b1;
          foreach (hist[i]) if (hist[i] != hist[0]) same = 1'b0;
          if (same && hist[0] != m_rx) begin
            m_rx  = hist[0];
            m_chg = 1'b1;
          end
        end
      end
      pend_v = v;
      if (v) pend = classify(w, k);
`ifdef FC_PRIMSEQ_RX_STATS_EN
      if (v) pend_bc = (w[31:24] == 8'hBC);
`endif
    end
`ifdef FC_PRIMSEQ_RX_STATS_EN
    if (!r && m_chg && m_sc < 65535) m_sc++;
`endif
  endtask

  task automatic cyc(input bit r, input bit s, input bit v,
                     input logic [31:0] w, input logic [3:0] k);
    reset = r; sync = s; valid = v; data = w; datak = k;
    @(posedge clk);
    model_step(r, s, v, w, k);
    #1;
    check("rx_seq", rx_seq, m_rx);
    check("rx_seq_change", rx_seq_change, m_chg);
    check("loss_of_sync", loss_of_sync, m_los);
`ifdef FC_PRIMSEQ_RX_STATS_EN
    check("stat_seq_changes", stat_seq_changes, m_sc);
    check("stat_other_os", stat_other_os, m_oo);
`endif
    if (rx_seq_change === 1'b1) pulses++;
  endtask

  task automatic send(input logic [31:0] w);
    cyc(1'b0, 1'b1, 1'b1, w, 4'b1000);
  endtask

  task automatic bubble(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0, 32'h0, 4'b0000);
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b1, 1'b0, 32'h0, 4'b0000);
    cyc(1'b1, 1'b1, 1'b0, 32'h0, 4'b0000);
  endtask

  logic [31:0] known [5];
  logic [31:0] cur;
  int          r;

  initial begin
    known[0] = W_IDLE; known[1] = W_LR; known[2] = W_LRR;
    known[3] = W_OLS;  known[4] = W_NOS;

    do_reset();
    check("reset_rx_seq", rx_seq, SEQ_NONE);
    check("reset_los", loss_of_sync, 1'b1);
    check("reset_chg", rx_seq_change, 1'b0);

    pulses = 0;
    send(W_LR); send(W_LR); send(W_LR);
    check("lr_not_yet", rx_seq, SEQ_NONE);
    bubble(1);
    check("lr_recog", rx_seq, SEQ_LR);
    bubble(2);
    check("lr_one_pulse", pulses, 1);

    do_reset();
    pulses = 0;
    send(W_LR); send(W_LR); send(W_NOS); send(W_LR); send(W_LR);
    bubble(2);
    check("broken_run", rx_seq, SEQ_NONE);
    check("broken_no_pulse", pulses, 0);
    send(W_LR); bubble(1);
    check("broken_then_lr", rx_seq, SEQ_LR);

    send(W_OLS); send(W_OLS); send(W_OLS); bubble(1);
    check("ols_recog", rx_seq, SEQ_OLS);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      send(W_OLS);
      bubble(int'($urandom_range(1, 4)));
    end
    check("ols_gaps_no_pulse", pulses, 0);
    cyc(1'b0, 1'b1, 1'b1, 32'h12345678, 4'b0000);
    send(W_NOS); send(W_NOS); send(W_NOS); bubble(2);
    check("nos_recog", rx_seq, SEQ_NOS);
    check("nos_one_pulse", pulses, 1);

    send(W_IDLE); send(W_IDLE); send(W_IDLE); bubble(1);
    check("idle_recog", rx_seq, SEQ_IDLE);
    pulses = 0;
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b1, W_IDLE, 4'b1000);
    check("los_rx_none", rx_seq, SEQ_NONE);
    check("los_one_pulse", pulses, 1);
    check("los_flag", loss_of_sync, 1'b1);
    send(W_IDLE); send(W_IDLE); bubble(2);
    check("resync_two_idle", rx_seq, SEQ_NONE);
    send(W_IDLE); bubble(1);
    check("resync_idle", rx_seq, SEQ_IDLE);

    send(W_LRR); send(W_LRR);
    cyc(1'b1, 1'b1, 1'b0, 32'h0, 4'b0000);
    send(W_LRR); bubble(1);
    check("rst_mid_rx", rx_seq, SEQ_NONE);
    send(W_LRR); send(W_LRR); send(W_LRR); bubble(1);
    check("lrr_recog", rx_seq, SEQ_LRR);

    cur = W_LR;
    for (int n = 0; n < 4000; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 15) cur = known[$urandom_range(0, 4)];
      r = int'($urandom_range(0, 99));
      if (r < 75)      data = cur;
      else if (r < 85) data = $urandom;
      else if (r < 92) data = W_RRDY;
      else             data = {8'hBC, 24'($urandom)};
      if (r < 75 || r >= 85) datak = 4'b1000;
      else if ($urandom_range(0, 1) == 0) datak = 4'b0000;
      else datak = 4'($urandom);
      cyc(($urandom_range(0, 399) == 0), ($urandom_range(0, 59) != 0),
          ($urandom_range(0, 3) != 0), data, datak);
    end

`ifdef FC_PRIMSEQ_RX_STATS_EN
    do_reset();
    for (int i = 0; i < 65540; i++) send(W_RRDY);
    bubble(1);
    check("stat_other_sat", stat_other_os, 16'hFFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
